mat4x2_operand_loader: RTL
==========================

# mat4x2_operand_loader

Sequential front end for the combinational 4x2 × 2x2 Q8.8 matrix multiplier. It receives matrix elements one 16-bit word per cycle over a valid/ready stream and assembles a complete operand set: A0..A7 row-major, then B0..B3 row-major. It then presents all twelve words in parallel, held stable, to the multiplier inputs until the consumer accepts them. It sits directly upstream of the multiplier and owns frame sequencing, so the multiplier never sees a partially updated operand set.

## Interface
- DW, 16, element width; Q8.8 signed, passed through unmodified.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid element.
- in_ready  output  1  loader accepts an element this cycle.
- in_data  input  DW  element, order A0..A7, B0..B3.
- reuse_b  input  1  sampled with the first word of a frame; only used when LOADER_REUSE_B_EN is defined.
- out_valid  output  1  A0..A7/B0..B3 form a complete, stable operand set.
- out_ready  input  1  consumer (multiplier capture stage) takes the set.
- A0..A7  output  DW each  matrix A elements, A[2r+c].
- B0..B3  output  DW each  matrix B elements, B[2r+c].
- frames_done  output  8  count of operand sets handed off; wraps 255→0.

## Operation
- States: LOAD_A, LOAD_B, HOLD.
- Reset: state = LOAD_A, word index = 0, in_ready = 1, out_valid = 0, all A/B registers = 0, frames_done = 0.
- Transfer: an element moves only when in_valid && in_ready.
- LOAD_A: each transfer writes A[idx] and increments idx.
  - After transfer of A7 (idx 7): go to LOAD_B and set idx = 0.
  - With reuse active for the frame: skip LOAD_B and go directly to HOLD.
- LOAD_B: each transfer writes B[idx]. After B3: go to HOLD.
- HOLD: in_ready = 0 and out_valid = 1. A/B registers are frozen.
  - On out_valid && out_ready: frames_done increments, state → LOAD_A, idx = 0.
- Output stability: registers not addressed by the current transfer keep their value, so A/B outputs change only in LOAD states.
- The consumer must sample only while out_valid = 1.
- in_data bits are stored verbatim; no arithmetic, rounding or sign handling.
- in_valid without in_ready (HOLD) is ignored; the upstream must hold its data.
- out_ready while out_valid = 0 has no effect.
- Reset mid-frame (any state): the partial frame is discarded and all registers return to reset values. frames_done is not incremented.
- frames_done increments modulo 256.

## Timing
- in_ready is a registered function of state: 1 in LOAD_A/LOAD_B, 0 in HOLD.
- Latency: out_valid rises on the cycle after the final element transfer.
  - Full frame: minimum 12 transfer cycles, then out_valid.
  - Reuse frame: 8 transfer cycles, then out_valid.
- Handoff: on the handshake edge, out_valid = 0 and in_ready = 1 in the next cycle. The next frame's A0 can transfer in that cycle.
- Minimum frame period: 13 cycles full, 9 cycles with reuse.
- Back-pressure in HOLD is unlimited; outputs stay constant for any duration.
- in_valid gaps in LOAD states stall the index without side effects.

## Configuration
- LOADER_REUSE_B_EN defined:
  - reuse_b is sampled on the A0 transfer.
  - If reuse_b = 1 and at least one full frame has completed since reset, the frame carries only A0..A7 and B0..B3 retain their previous values.
  - If reuse_b = 1 before any full frame, it is treated as 0 and the full 12-word frame is loaded.
- LOADER_REUSE_B_EN undefined: reuse_b is ignored and every frame is exactly 12 words.

## Test plan
- Reset then idle: check in_ready = 1, out_valid = 0, all outputs 0, frames_done = 0.
- Full frame, continuous valid:
  - Stream A = 0080,0180,0080,FC80,FE80,0180,FC80,FC80 and B = FC80×4, out_ready = 1.
  - Expect out_valid on cycle 13 for one cycle with exact word mapping, then frames_done = 1.
- Back-pressure:
  - Stream the same frame with out_ready = 0 for 20 cycles.
  - Expect outputs constant, in_ready = 0 and extra in_valid words ignored.
  - Raise out_ready: expect handoff, frames_done = 1 and in_ready = 1 on the next cycle.
- Gapped input and mid-frame reset:
  - Toggle in_valid every other cycle: expect correct assembly of B = FF00,FF00,0100,FE00.
  - Assert rst after 5 words: expect all registers 0 and the next 12 words form a clean frame.
- Reuse (macro defined):
  - First send a full frame with B = FF00,FF00,0100,FE00.
  - Then send reuse_b = 1 with 8 A words: expect out_valid after 8 transfers and B unchanged.
  - Macro undefined, same stimulus: expect no out_valid until 12 words are received.
- Counter wrap: complete 256 frames and expect frames_done to go 255 → 0.

Source files
------------

// File: rtl/mat4x2_operand_loader.sv
// Operand loader for the 4x2 x 2x2 Q8.8 multiplier: assembles A0..A7, B0..B3 from a word stream
// and holds the full set stable until handed off. Optional B reuse guarded by LOADER_REUSE_B_EN.
module mat4x2_operand_loader #(
   parameter int DW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_in_data,
   input  logic          i_reuse_b,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [DW-1:0] o_a0,
   output logic [DW-1:0] o_a1,
   output logic [DW-1:0] o_a2,
   output logic [DW-1:0] o_a3,
   output logic [DW-1:0] o_a4,
   output logic [DW-1:0] o_a5,
   output logic [DW-1:0] o_a6,
   output logic [DW-1:0] o_a7,
   output logic [DW-1:0] o_b0,
   output logic [DW-1:0] o_b1,
   output logic [DW-1:0] o_b2,
   output logic [DW-1:0] o_b3,
   output logic [7:0]    o_frames_done
);

   // state  | meaning
   // LOAD_A | accepting A0..A7, r_idx = next A element
   // LOAD_B | accepting B0..B3, r_idx = next B element
   // HOLD   | operand set complete and frozen, waiting for out_ready
   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [2:0]    r_idx;
   logic [2:0]    w_idx_nxt;
   logic [DW-1:0] r_a [8];
   logic [DW-1:0] r_b [4];
   logic          r_in_ready;
   logic          r_out_valid;
   logic [7:0]    r_frames_done;

   logic          w_xfer;
   logic          w_handoff;
   logic          w_wr_a;
   logic          w_wr_b;
   logic          w_skip_b;

   assign w_xfer    = i_in_valid && r_in_ready;
   assign w_handoff = r_out_valid && i_out_ready;

`ifdef LOADER_REUSE_B_EN
   // Reuse is only honoured once a B matrix has actually been loaded since reset.
   logic r_b_loaded;
   logic r_reuse_frame;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_b_loaded    <= 1'b0;
         r_reuse_frame <= 1'b0;
      end else begin
         if (w_handoff)
            r_b_loaded <= 1'b1;
         if (w_wr_a && (r_idx == 3'd0))
            r_reuse_frame <= i_reuse_b && r_b_loaded;
      end
   end

   assign w_skip_b = r_reuse_frame;
`else
   logic w_reuse_b_unused;
   assign w_reuse_b_unused = i_reuse_b;
   assign w_skip_b         = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wr_a      = 1'b0;
      w_wr_b      = 1'b0;
      case (r_state)
         LOAD_A: begin
            if (w_xfer) begin
               w_wr_a = 1'b1;
               if (r_idx == 3'd7) begin
                  w_idx_nxt   = 3'd0;
                  w_state_nxt = w_skip_b ? HOLD : LOAD_B;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         LOAD_B: begin
            if (w_xfer) begin
               w_wr_b = 1'b1;
               if (r_idx == 3'd3) begin
                  w_idx_nxt   = 3'd0;
                  w_state_nxt = HOLD;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         HOLD: begin
            if (w_handoff) begin
               w_idx_nxt   = 3'd0;
               w_state_nxt = LOAD_A;
            end
         end
         default: begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = LOAD_A;
         end
      endcase
   end

   // Handshake flags are registered from the next state so they line up with r_state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= LOAD_A;
         r_idx         <= 3'd0;
         r_in_ready    <= 1'b1;
         r_out_valid   <= 1'b0;
         r_frames_done <= 8'd0;
         for (int i = 0; i < 8; i++) r_a[i] <= '0;
         for (int i = 0; i < 4; i++) r_b[i] <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_in_ready  <= (w_state_nxt != HOLD);
         r_out_valid <= (w_state_nxt == HOLD);
         if (w_wr_a)
            r_a[r_idx] <= i_in_data;
         if (w_wr_b)
            r_b[r_idx[1:0]] <= i_in_data;
         if (w_handoff)
            r_frames_done <= r_frames_done + 8'd1;
      end
   end

   assign o_in_ready    = r_in_ready;
   assign o_out_valid   = r_out_valid;
   assign o_frames_done = r_frames_done;
   assign o_a0 = r_a[0];
   assign o_a1 = r_a[1];
   assign o_a2 = r_a[2];
   assign o_a3 = r_a[3];
   assign o_a4 = r_a[4];
   assign o_a5 = r_a[5];
   assign o_a6 = r_a[6];
   assign o_a7 = r_a[7];
   assign o_b0 = r_b[0];
   assign o_b1 = r_b[1];
   assign o_b2 = r_b[2];
   assign o_b3 = r_b[3];

endmodule
